// File: rtl/byte_mem_sequencer.sv
// Memory-side responder for the processor load/store handshake.
// Moves 1/2/4/8 bytes (little-endian) over a byte-wide synchronous RAM port,
// one byte per cycle, and returns sign- or zero-extended load data on mem_o.
module byte_mem_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_start,
    input  logic        sel_mem_operation,
    input  logic [1:0]  sel_mem_size,
    input  logic [2:0]  sel_mem_extension,
    input  logic [63:0] addr,
    input  logic [63:0] data_i,
    output logic        memory_done,
    output logic [63:0] mem_o,
    output logic [63:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     asm_q;
    logic [XLEN-1:0]     mem_o_q;
    logic [XLEN-1:0]     ram_addr_q;
    logic [7:0]          ram_wdata_q;
    logic                ram_we_q;
    logic                done_q;
    logic [1:0]          size_q;
    logic                zext_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [CNT_W-1:0]    last_beat_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic [CNT_W-1:0]    cap_lane_c;
    logic [XLEN-1:0]     asm_full_c;
    logic [XLEN-1:0]     load_ext_c;
    logic                fill_c;
    logic                unused_ext_c;

    // Only bit 2 of the load func3 selects zero/sign extension.
    assign unused_ext_c = ^sel_mem_extension[1:0];

    // Beat bookkeeping: final beat index, next beat, and lane of the byte now arriving.
    always_comb begin
        last_beat_c = '0;
        case (size_q)
            2'd0:    last_beat_c = CNT_W'(0);
            2'd1:    last_beat_c = CNT_W'(1);
            2'd2:    last_beat_c = CNT_W'(3);
            default: last_beat_c = CNT_W'(7);
        endcase
        cnt_inc_c  = cnt_q + CNT_W'(1);
        cap_lane_c = cnt_q - CNT_W'(RD_LAT);
    end

    // Final assembly (last byte merged straight from the RAM) and extension.
    always_comb begin
        asm_full_c = asm_q;
        asm_full_c[{cnt_q, 3'b000} +: 8] = ram_rdata;
        fill_c     = ~zext_q;
        load_ext_c = asm_full_c;
        case (size_q)
            2'd0:    load_ext_c = {{56{fill_c & asm_full_c[7]}},  asm_full_c[7:0]};
            2'd1:    load_ext_c = {{48{fill_c & asm_full_c[15]}}, asm_full_c[15:0]};
            2'd2:    load_ext_c = {{32{fill_c & asm_full_c[31]}}, asm_full_c[31:0]};
            default: load_ext_c = asm_full_c;
        endcase
    end

    // Request sequencer: latches the request, walks the bytes, issues the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wdata_q     <= '0;
            asm_q       <= '0;
            mem_o_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            done_q      <= 1'b0;
            size_q      <= '0;
            zext_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (memory_start) begin
                        ram_addr_q <= addr;
                        wdata_q    <= data_i;
                        size_q     <= sel_mem_size;
                        zext_q     <= sel_mem_extension[2];
                        cnt_q      <= '0;
                        asm_q      <= '0;
                        if (sel_mem_operation) begin
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= data_i[7:0];
                            state_q     <= S_STORE;
                        end else begin
                            ram_we_q    <= 1'b0;
                            state_q     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // Byte for the previous beat arrives this cycle.
                    if (cnt_q != '0) begin
                        asm_q[{cap_lane_c, 3'b000} +: 8] <= ram_rdata;
                    end
                    if (cnt_q == last_beat_c) begin
                        state_q <= S_DRAIN;
                    end else begin
                        cnt_q      <= cnt_inc_c;
                        ram_addr_q <= ram_addr_q + 64'd1;
                    end
                end
                S_DRAIN: begin
                    asm_q   <= asm_full_c;
                    mem_o_q <= load_ext_c;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_STORE: begin
                    if (cnt_q == last_beat_c) begin
                        ram_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q       <= cnt_inc_c;
                        ram_addr_q  <= ram_addr_q + 64'd1;
                        ram_wdata_q <= wdata_q[{cnt_inc_c, 3'b000} +: 8];
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign memory_done = done_q;
    assign mem_o       = mem_o_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_we      = ram_we_q;

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Self-checking bench for byte_mem_sequencer: byte RAM model plus a reference
// memory that computes expected load results directly from byte contents.
module tb_byte_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memory_start = 1'b0;
    logic        sel_mem_operation = 1'b0;
    logic [1:0]  sel_mem_size = 2'd0;
    logic [2:0]  sel_mem_extension = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] data_i = 64'd0;
    logic        memory_done;
    logic [63:0] mem_o;
    logic [63:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = 8'd0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram  [logic [63:0]];
    logic [7:0]  gold [logic [63:0]];
    logic [63:0] exp_mem_o = 64'd0;

    byte_mem_sequencer dut (
        .clk(clk), .reset(reset), .memory_start(memory_start),
        .sel_mem_operation(sel_mem_operation), .sel_mem_size(sel_mem_size),
        .sel_mem_extension(sel_mem_extension), .addr(addr), .data_i(data_i),
        .memory_done(memory_done), .mem_o(mem_o), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten bytes hold a deterministic pattern derived from the address.
    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [63:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] gold_rd(input logic [63:0] a);
        return gold.exists(a) ? gold[a] : init_byte(a);
    endfunction

    // Synchronous byte RAM, one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        ram_rdata <= ram_rd(ram_addr);
        if (ram_we) ram[ram_addr] = ram_wdata;
    end

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                             input logic [2:0] ext);
        int n = 1 << sz;
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v = v | (64'(gold_rd(a + 64'(k))) << (8 * k));
        if (sz != 2'd3 && ext[2] == 1'b0 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
        int n = 1 << sz;
        for (int k = 0; k < n; k++) gold[a + 64'(k)] = 8'(d >> (8 * k));
    endtask

    // Drive one request; returns cycles from the start edge to done (0 = timeout) and ram_we cycles.
    task automatic run_req(input bit op, input logic [1:0] sz, input logic [2:0] ext,
                           input logic [63:0] a, input logic [63:0] d,
                           output int lat, output int we_cycles);
        @(negedge clk);
        sel_mem_operation = op; sel_mem_size = sz; sel_mem_extension = ext;
        addr = a; data_i = d; memory_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        memory_start = 1'b0;
        sel_mem_operation = 1'($urandom); sel_mem_size = 2'($urandom);
        sel_mem_extension = 3'($urandom); addr = {$urandom, $urandom}; data_i = {$urandom, $urandom};
        lat = 0; we_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            if (ram_we) we_cycles++;
            if (memory_done) begin lat = c; break; end
            @(negedge clk);
        end
        if (op) ref_store(a, sz, d);
        else exp_mem_o = ref_load(a, sz, ext);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({memory_done, ram_we, mem_o, ram_addr, ram_wdata} !== 138'd0) begin
            errors++;
            $display("FAIL reset_values: done=%b we=%b mem_o=%h addr=%h wdata=%h required all zero",
                     memory_done, ram_we, mem_o, ram_addr, ram_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        int lat, we;
        logic [63:0] got;
        run_req(1'b1, 2'd3, 3'd0, 64'h100, 64'h1122334455667788, lat, we);
        got = 64'd0;
        for (int k = 0; k < 8; k++) got = got | (64'(ram_rd(64'h100 + 64'(k))) << (8 * k));
        checks++;
        if (lat != 9 || we != 8 || got !== 64'h1122334455667788 || mem_o !== 64'd0) begin
            errors++;
            $display("FAIL store_double: lat=%0d we=%0d ram=%h mem_o=%h required 9 8 1122334455667788 0",
                     lat, we, got, mem_o);
        end
        @(negedge clk);
        checks++;
        if (memory_done !== 1'b0) begin
            errors++; $display("FAIL done_single_pulse: done=%b required 0", memory_done);
        end
        run_req(1'b0, 2'd0, 3'b000, 64'h100, 64'd0, lat, we);
        checks++;
        if (lat != 3 || mem_o !== 64'hFFFFFFFFFFFFFF88) begin
            errors++; $display("FAIL load_byte_signed: lat=%0d mem_o=%h required 3 ffffffffffffff88", lat, mem_o);
        end
        run_req(1'b0, 2'd0, 3'b100, 64'h100, 64'd0, lat, we);
        checks++;
        if (mem_o !== 64'h88 || we != 0) begin
            errors++; $display("FAIL load_byte_zero: mem_o=%h we=%0d required 88 0", mem_o, we);
        end
        run_req(1'b0, 2'd1, 3'b001, 64'h106, 64'd0, lat, we);
        checks++;
        if (lat != 4 || mem_o !== 64'h1122) begin
            errors++; $display("FAIL load_half: lat=%0d mem_o=%h required 4 1122", lat, mem_o);
        end
        run_req(1'b0, 2'd2, 3'b010, 64'h100, 64'd0, lat, we);
        checks++;
        if (lat != 6 || mem_o !== 64'h55667788) begin
            errors++; $display("FAIL load_word: lat=%0d mem_o=%h required 6 55667788", lat, mem_o);
        end
        run_req(1'b1, 2'd2, 3'd0, 64'h200, 64'hDEAD_0000_8899AABB, lat, we);
        checks++;
        if (lat != 5 || we != 4 || mem_o !== 64'h55667788) begin
            errors++; $display("FAIL store_word: lat=%0d we=%0d mem_o=%h required 5 4 55667788", lat, we, mem_o);
        end
        run_req(1'b0, 2'd2, 3'b000, 64'h200, 64'd0, lat, we);
        checks++;
        if (mem_o !== 64'hFFFFFFFF8899AABB) begin
            errors++; $display("FAIL load_word_signed_neg: mem_o=%h required ffffffff8899aabb", mem_o);
        end
        run_req(1'b0, 2'd2, 3'b110, 64'h200, 64'd0, lat, we);
        checks++;
        if (mem_o !== 64'h8899AABB) begin
            errors++; $display("FAIL load_word_zero: mem_o=%h required 8899aabb", mem_o);
        end
        run_req(1'b1, 2'd1, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'hBEEF, lat, we);
        checks++;
        if (lat != 3 || ram_rd(64'hFFFFFFFFFFFFFFFF) !== 8'hEF || ram_rd(64'h0) !== 8'hBE) begin
            errors++;
            $display("FAIL store_wrap: lat=%0d top=%h zero=%h required 3 ef be",
                     lat, ram_rd(64'hFFFFFFFFFFFFFFFF), ram_rd(64'h0));
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat, we;
        @(negedge clk);
        sel_mem_operation = 1'b0; sel_mem_size = 2'd3; sel_mem_extension = 3'd0;
        addr = 64'h100; memory_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        memory_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (mem_o !== 64'd0 || memory_done !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: mem_o=%h done=%b we=%b required 0 0 0", mem_o, memory_done, ram_we);
        end
        exp_mem_o = 64'd0;
        for (int c = 0; c < 15; c++) begin
            if (memory_done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_mid_no_done: done pulses=%0d required 0", seen);
        end
        run_req(1'b0, 2'd3, 3'd0, 64'h100, 64'd0, lat, we);
        checks++;
        if (lat != 10 || mem_o !== 64'h1122334455667788) begin
            errors++; $display("FAIL reset_mid_recover: lat=%0d mem_o=%h required 10 1122334455667788", lat, mem_o);
        end
    endtask

    task automatic test_ignored_start();
        int done_at = 0;
        int extra = 0;
        int we_seen = 0;
        @(negedge clk);
        sel_mem_operation = 1'b0; sel_mem_size = 2'd3; sel_mem_extension = 3'd0;
        addr = 64'h200; memory_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            memory_start = (c == 3 || c == 6) ? 1'b1 : 1'b0;
            if (c == 3) sel_mem_operation = 1'b1;
            if (ram_we) we_seen++;
            if (memory_done) begin
                if (done_at == 0) done_at = c;
                else extra++;
            end
        end
        exp_mem_o = ref_load(64'h200, 2'd3, 3'd0);
        checks++;
        if (done_at != 10 || extra != 0 || we_seen != 0 || mem_o !== exp_mem_o) begin
            errors++;
            $display("FAIL ignored_start: done_at=%0d extra=%0d we=%0d mem_o=%h required 10 0 0 %h",
                     done_at, extra, we_seen, mem_o, exp_mem_o);
        end
    endtask

    task automatic test_back_to_back();
        int count = 0;
        int last_c = 0;
        int bad_gap = 0;
        int bad_val = 0;
        logic [63:0] a;
        a = 64'h1000 + 64'($urandom_range(0, 15));
        exp_mem_o = ref_load(a, 2'd1, 3'd0);
        @(negedge clk);
        sel_mem_operation = 1'b0; sel_mem_size = 2'd1; sel_mem_extension = 3'd0;
        addr = a; memory_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (memory_done) begin
                count++;
                if (c - last_c != ((count == 1) ? 4 : 5)) bad_gap++;
                if (mem_o !== exp_mem_o) bad_val++;
                last_c = c;
                if (count == 4) memory_start = 1'b0;
            end
        end
        memory_start = 1'b0;
        checks++;
        if (count != 4 || bad_gap != 0 || bad_val != 0) begin
            errors++;
            $display("FAIL back_to_back: dones=%0d bad_gaps=%0d bad_vals=%0d required 4 0 0",
                     count, bad_gap, bad_val);
        end
    endtask

    task automatic test_random();
        int lat, we, n;
        int bad = 0;
        bit op;
        logic [1:0]  sz;
        logic [2:0]  ext;
        logic [63:0] a, d;
        for (int i = 0; i < 150; i++) begin
            op  = 1'($urandom);
            sz  = 2'($urandom);
            ext = 3'($urandom);
            d   = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       a = 64'h1000 + 64'($urandom_range(0, 15));
                1:       a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 15));
                default: a = 64'hABCD0000 + 64'($urandom_range(0, 15));
            endcase
            n = 1 << sz;
            run_req(op, sz, ext, a, d, lat, we);
            checks++;
            if (lat != (op ? n + 1 : n + 2) || we != (op ? n : 0) || mem_o !== exp_mem_o) begin
                errors++;
                if (bad < 8)
                    $display("FAIL random_txn %0d: op=%0d sz=%0d addr=%h lat=%0d we=%0d mem_o=%h required lat=%0d we=%0d mem_o=%h",
                             i, op, sz, a, lat, we, mem_o, op ? n + 1 : n + 2, op ? n : 0, exp_mem_o);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
